spi_master_ctrl: RTL and testbench
==================================

// Module: spi_master_ctrl
// PURPOSE
//  Synthesizable SPI master. Serialises one DATA_WIDTH word per transfer on mosi0 and
//  deserialises miso0 at the same time, driving sclk and cs_n. It is the initiator end of
//  spi_if and runs against the slave agent BFM in the slave HDL top.
//  The host side is a valid/ready request plus a one-cycle response pulse.
// PARAMETERS
//  DATA_WIDTH  8  bits per transfer (>=2)
//  CLK_DIV     2  pclk cycles per sclk half-period (>=1)
//  CPOL        0  sclk idle level
//  CPHA        0  0: sample on leading edge, drive on trailing edge; 1: the reverse
//  MSB_FIRST   1  1: bit DATA_WIDTH-1 goes first; 0: bit 0 goes first
// PORTS
//  pclk      in   1           system clock; all logic on posedge
//  areset    in   1           reset, synchronous, active-high
//  tx_valid  in   1           transfer request
//  tx_ready  out  1           high only in IDLE; accept when tx_valid&&tx_ready
//  tx_data   in   DATA_WIDTH  word to send; captured at accept
//  rx_valid  out  1           one-cycle pulse at end of transfer
//  rx_data   out  DATA_WIDTH  received word; held until the next rx_valid
//  busy      out  1           high from the cycle after accept until back in IDLE
//  sclk      out  1           serial clock, registered
//  cs_n      out  1           slave select, active-low, registered
//  mosi0     out  1           serial data out, registered
//  miso0     in   1           serial data in
// BEHAVIOUR
//  Reset values: tx_ready=1, rx_valid=0, rx_data=0, busy=0, sclk=CPOL, cs_n=1, mosi0=0.
//  Reset also clears the FSM to IDLE and zeroes all counters.
//  FSM: IDLE -> CS_SETUP -> XFER -> CS_HOLD -> IDLE.
//  - IDLE: accept in cycle T. Latch tx_data into the shift register.
//    At T+1: cs_n=0, busy=1, enter CS_SETUP.
//    CPHA=0 only: mosi0 also shows the first bit at T+1.
//  - CS_SETUP: last CLK_DIV cycles; sclk stays at CPOL; then enter XFER.
//  - XFER: div_cnt counts 0..CLK_DIV-1. On wrap, sclk toggles.
//    The transfer has exactly 2*DATA_WIDTH toggles (edge_cnt width $clog2(2*DATA_WIDTH+1)).
//    Odd toggles are leading edges; even toggles are trailing edges.
//    Sample edge: miso0 is shifted into rx_shift on the pclk cycle of that toggle.
//    Drive edge: the next bit appears on mosi0 on the same cycle.
//    For CPHA=0, no drive after the final trailing edge.
//  - CS_HOLD: entered after the final toggle, with sclk back at CPOL. Lasts CLK_DIV cycles.
//    In its last cycle's next edge: cs_n=1, rx_valid=1, rx_data=rx_shift, busy=0.
//    Return to IDLE, where tx_ready=1 again.
//  Latency: accept at T -> rx_valid at T + CLK_DIV*(2*DATA_WIDTH+2) + 1.
//    With defaults this is T+37.
//  cs_n is high for at least 1 pclk cycle between transfers.
//  Back-to-back: a tx_valid held high is accepted in the cycle that rx_valid is asserted.
//  tx_valid while busy: ignored (tx_ready=0); tx_data changes have no effect mid-transfer.
//  rx_valid has no backpressure; rx_data is overwritten only by the next completion.
//  LSB-first bit order (MSB_FIRST=0) is a mirror of the shift direction; timing is unchanged.
//  Reset mid-transfer: all outputs take reset values on the next posedge, with no rx_valid.
//    The partial word is discarded.
//  mosi0 holds its last value in CS_HOLD and IDLE until the next transfer drives it.
// TESTING
//  Mode0, defaults: send 8'hA5, BFM returns 8'h3C.
//    -> mosi0 at sclk rises reads 1,0,1,0,0,1,0,1.
//    -> rx_valid at T+37 with rx_data=8'h3C; 16 sclk toggles.
//  CPOL=1, CPHA=1: send 8'h81, BFM returns 8'h7E.
//    -> sclk idles 1; sampling on rising (trailing) edges; rx_data=8'h7E.
//  MSB_FIRST=0, CLK_DIV=3: send 8'h01.
//    -> first mosi0 bit=1, then seven 0s.
//    -> rx_valid at T+3*18+1=T+55.
//  Back-to-back: tx_valid held with 8'h11 then 8'h22.
//    -> second accept in the rx_valid cycle of the first.
//    -> cs_n high exactly 1 cycle between transfers.
//    -> both words are received correctly by the BFM.
//  Protocol abuse: pulse tx_valid with 8'hFF at T+5 mid-transfer -> ignored, no extra transfer.
//  Reset: assert areset at the 5th sclk toggle.
//    -> next cycle cs_n=1, sclk=CPOL, busy=0, no rx_valid.
//    -> a new 8'h5A transfer then completes normally.

Source files
------------

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - SPI master: one DATA_WIDTH word per transfer, valid/ready request, pulsed response.
// Mode (CPOL/CPHA), bit order and sclk divider are fixed at elaboration.
module spi_master_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CLK_DIV    = 2,
  parameter bit          CPOL       = 1'b0,
  parameter bit          CPHA       = 1'b0,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic                  pclk,
  input  logic                  areset,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  busy,
  output logic                  sclk,
  output logic                  cs_n,
  output logic                  mosi0,
  input  logic                  miso0
);

  localparam int unsigned EW    = $clog2(2*DATA_WIDTH+1);
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV-1);
  localparam logic [EW-1:0]    EDGE_LAST = EW'(2*DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, CS_SETUP, XFER, CS_HOLD} state_e;

  state_e                  state_q;
  logic [DIV_W-1:0]        div_q;
  logic [EW-1:0]           edge_q;
  logic [DATA_WIDTH-1:0]   tx_shift_q;
  logic [DATA_WIDTH-1:0]   rx_shift_q;
  logic [DATA_WIDTH-1:0]   rx_data_q;
  logic                    rx_valid_q;
  logic                    tx_ready_q;
  logic                    busy_q;
  logic                    sclk_q;
  logic                    cs_n_q;
  logic                    mosi_q;

  logic [EW-1:0]           edge_d;
  logic                    div_wrap;
  logic                    sample_edge;
  logic                    drive_edge;

  function automatic logic head(input logic [DATA_WIDTH-1:0] v);
    return MSB_FIRST ? v[DATA_WIDTH-1] : v[0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] v);
    return MSB_FIRST ? (v << 1) : (v >> 1);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] v,
                                                      input logic b);
    return MSB_FIRST ? {v[DATA_WIDTH-2:0], b} : {b, v[DATA_WIDTH-1:1]};
  endfunction

  // edge_d is the 1-based number of the toggle about to happen; odd numbers are leading edges
  always_comb begin
    edge_d      = edge_q + EW'(1);
    div_wrap    = (div_q == DIV_LAST);
    sample_edge = (edge_d[0] != CPHA);
    drive_edge  = !sample_edge && (edge_d != EDGE_LAST);
  end

  always_ff @(posedge pclk) begin
    if (areset) begin
      state_q    <= IDLE;
      div_q      <= '0;
      edge_q     <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      sclk_q     <= CPOL;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tx_valid) begin
            state_q    <= CS_SETUP;
            div_q      <= '0;
            edge_q     <= '0;
            cs_n_q     <= 1'b0;
            busy_q     <= 1'b1;
            tx_ready_q <= 1'b0;
            // CPHA=0 presents the first bit with cs_n; CPHA=1 waits for the first leading edge
            if (CPHA) begin
              tx_shift_q <= tx_data;
            end else begin
              mosi_q     <= head(tx_data);
              tx_shift_q <= shift_out(tx_data);
            end
          end
        end
        CS_SETUP: begin
          if (div_wrap) begin
            state_q <= XFER;
            div_q   <= '0;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        XFER: begin
          if (div_wrap) begin
            div_q  <= '0;
            sclk_q <= ~sclk_q;
            edge_q <= edge_d;
            if (sample_edge) rx_shift_q <= shift_in(rx_shift_q, miso0);
            if (drive_edge) begin
              mosi_q     <= head(tx_shift_q);
              tx_shift_q <= shift_out(tx_shift_q);
            end
            if (edge_d == EDGE_LAST) state_q <= CS_HOLD;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        CS_HOLD: begin
          if (div_wrap) begin
            state_q    <= IDLE;
            div_q      <= '0;
            cs_n_q     <= 1'b1;
            rx_valid_q <= 1'b1;
            rx_data_q  <= rx_shift_q;
            busy_q     <= 1'b0;
            tx_ready_q <= 1'b1;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_ready = tx_ready_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign busy     = busy_q;
  assign sclk     = sclk_q;
  assign cs_n     = cs_n_q;
  assign mosi0    = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - directed bench for spi_master_ctrl in three modes with an inline slave model.
module tb_spi_master_ctrl;

  logic pclk   = 1'b0;
  logic areset = 1'b1;
  always #5 pclk = ~pclk;

  logic [2:0] tx_valid = '0;
  logic [2:0] tx_ready, rx_valid, busy, sclk, cs_n, mosi;
  logic [7:0] tx_data  [3];
  logic [7:0] rx_data  [3];
  logic [7:0] slv_word [3];
  logic [7:0] slv_rx   [3];
  logic [4:0] tcnt     [3];

  int tests = 0;
  int fails = 0;

  // instance 0: mode 0, div 2; instance 1: CPOL=1 CPHA=1, div 2; instance 2: mode 0, LSB first, div 3
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam bit          PH  = (g == 1);
    localparam bit          PO  = (g == 1);
    localparam bit          MSB = (g != 2);
    localparam int unsigned DIV = (g == 2) ? 3 : 2;

    logic       miso_w;
    logic [4:0] tc        = '0;
    logic [7:0] srx       = '0;
    logic       prev_cs   = 1'b1;
    logic       prev_sclk = PO;
    logic [4:0] tm1;
    logic [2:0] idx;

    spi_master_ctrl #(
      .DATA_WIDTH(8), .CLK_DIV(DIV), .CPOL(PO), .CPHA(PH), .MSB_FIRST(MSB)
    ) u_dut (
      .pclk(pclk), .areset(areset),
      .tx_valid(tx_valid[g]), .tx_ready(tx_ready[g]), .tx_data(tx_data[g]),
      .rx_valid(rx_valid[g]), .rx_data(rx_data[g]), .busy(busy[g]),
      .sclk(sclk[g]), .cs_n(cs_n[g]), .mosi0(mosi[g]), .miso0(miso_w)
    );

    // slave: capture mosi on the master's sample edges, shift miso on its drive edges
    always @(sclk[g] or cs_n[g]) begin
      if (cs_n[g] === 1'b0 && prev_cs === 1'b1) begin
        tc  = '0;
        srx = '0;
      end else if (cs_n[g] === 1'b0 && sclk[g] !== prev_sclk) begin
        if (tc[0] == PH) srx = MSB ? {srx[6:0], mosi[g]} : {mosi[g], srx[7:1]};
        tc = tc + 5'd1;
      end
      prev_cs   = cs_n[g];
      prev_sclk = sclk[g];
    end

    assign tm1       = tc - 5'd1;
    assign idx       = PH ? ((tc == 5'd0) ? 3'd0 : tm1[3:1]) : tc[3:1];
    assign miso_w    = MSB ? slv_word[g][3'd7 - idx] : slv_word[g][idx];
    assign slv_rx[g] = srx;
    assign tcnt[g]   = tc;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_xfer(input int i, input logic [7:0] d, input logic [7:0] sw);
    slv_word[i] = sw;
    tx_data[i]  = d;
    tx_valid[i] = 1'b1;
    @(posedge pclk);
    #1;
    tx_valid[i] = 1'b0;
  endtask

  task automatic wait_rx(input int i, output int n);
    n = 0;
    while (rx_valid[i] !== 1'b1 && n < 400) begin
      @(posedge pclk);
      #1;
      n++;
    end
  endtask

  task automatic check_done(input string tag, input int i, input int n, input int lat,
                            input logic [7:0] exp_rx, input logic [7:0] exp_mosi);
    check({tag, "_lat"},    n, lat);
    check({tag, "_rx"},     rx_data[i], exp_rx);
    check({tag, "_mosi"},   slv_rx[i], exp_mosi);
    check({tag, "_toggle"}, tcnt[i], 16);
    check({tag, "_busy"},   busy[i], 0);
    check({tag, "_csn"},    cs_n[i], 1);
    check({tag, "_rdy"},    tx_ready[i], 1);
  endtask

  initial begin
    int n;
    int k;
    int low_cnt;
    int rv_cnt;
    for (int i = 0; i < 3; i++) begin
      tx_data[i]  = '0;
      slv_word[i] = '0;
    end
    repeat (3) @(posedge pclk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst%0d_rdy", i),  tx_ready[i], 1);
      check($sformatf("rst%0d_rv", i),   rx_valid[i], 0);
      check($sformatf("rst%0d_rx", i),   rx_data[i], 0);
      check($sformatf("rst%0d_busy", i), busy[i], 0);
      check($sformatf("rst%0d_csn", i),  cs_n[i], 1);
      check($sformatf("rst%0d_mosi", i), mosi[i], 0);
      check($sformatf("rst%0d_sclk", i), sclk[i], (i == 1) ? 1 : 0);
    end
    areset = 1'b0;
    @(posedge pclk);
    #1;

    start_xfer(0, 8'hA5, 8'h3C);
    check("m0_busy_t1", busy[0], 1);
    check("m0_csn_t1",  cs_n[0], 0);
    check("m0_rdy_t1",  tx_ready[0], 0);
    check("m0_mosi_t1", mosi[0], 1);
    wait_rx(0, n);
    check_done("m0", 0, n, 36, 8'h3C, 8'hA5);
    @(posedge pclk);
    #1;
    check("m0_rv_pulse", rx_valid[0], 0);
    check("m0_rx_hold",  rx_data[0], 8'h3C);

    start_xfer(1, 8'h81, 8'h7E);
    check("m3_sclk_setup", sclk[1], 1);
    wait_rx(1, n);
    check_done("m3", 1, n, 36, 8'h7E, 8'h81);
    check("m3_sclk_idle", sclk[1], 1);

    start_xfer(2, 8'h01, 8'hB4);
    check("lsb_mosi_t1", mosi[2], 1);
    wait_rx(2, n);
    check_done("lsb", 2, n, 54, 8'hB4, 8'h01);

    slv_word[0] = 8'h5C;
    tx_data[0]  = 8'h11;
    tx_valid[0] = 1'b1;
    @(posedge pclk);
    #1;
    tx_data[0] = 8'h22;
    wait_rx(0, n);
    check_done("b2b1", 0, n, 36, 8'h5C, 8'h11);
    @(posedge pclk);
    #1;
    check("b2b_csn_gap", cs_n[0], 0);
    check("b2b_busy2",   busy[0], 1);
    tx_valid[0] = 1'b0;
    slv_word[0] = 8'hC5;
    wait_rx(0, n);
    check_done("b2b2", 0, n, 36, 8'hC5, 8'h22);

    start_xfer(0, 8'h96, 8'h69);
    repeat (4) @(posedge pclk);
    #1;
    tx_data[0]  = 8'hFF;
    tx_valid[0] = 1'b1;
    check("abuse_rdy", tx_ready[0], 0);
    @(posedge pclk);
    #1;
    tx_valid[0] = 1'b0;
    wait_rx(0, n);
    check_done("abuse", 0, n, 31, 8'h69, 8'h96);
    low_cnt = 0;
    rv_cnt  = 0;
    repeat (60) begin
      @(posedge pclk);
      #1;
      low_cnt += (cs_n[0] == 1'b0) ? 1 : 0;
      rv_cnt  += (rx_valid[0] == 1'b1) ? 1 : 0;
    end
    check("abuse_no_cs",  low_cnt, 0);
    check("abuse_no_rv",  rv_cnt, 0);

    start_xfer(0, 8'hC3, 8'h0F);
    k = 0;
    while (tcnt[0] != 5'd5 && k < 100) begin
      @(posedge pclk);
      #1;
      k++;
    end
    check("rst_mid_reach", tcnt[0], 5);
    areset = 1'b1;
    @(posedge pclk);
    #1;
    areset = 1'b0;
    check("rst_mid_csn",  cs_n[0], 1);
    check("rst_mid_sclk", sclk[0], 0);
    check("rst_mid_busy", busy[0], 0);
    check("rst_mid_rv",   rx_valid[0], 0);
    check("rst_mid_rdy",  tx_ready[0], 1);
    check("rst_mid_mosi", mosi[0], 0);
    check("rst_mid_sclk1", sclk[1], 1);
    rv_cnt = 0;
    repeat (40) begin
      @(posedge pclk);
      #1;
      rv_cnt += (rx_valid[0] == 1'b1) ? 1 : 0;
    end
    check("rst_mid_no_rv", rv_cnt, 0);
    start_xfer(0, 8'h5A, 8'hE7);
    wait_rx(0, n);
    check_done("post_rst", 0, n, 36, 8'hE7, 8'h5A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
